// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared defaults and index helpers for the fifo write arbiter
package fifo_arb_pkg;

  localparam int DSIZE_DEF = 5;
  localparam int NREQ_DEF  = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Explicit wrap so non-power-of-two requester counts rotate correctly.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority picker
// Scans ptr_i, ptr_i+1, ... (mod NREQ) and returns the first asserted request.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int SW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [SW-1:0]   ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [SW-1:0]   idx_o,
  output logic            any_o
);

  logic [SW:0]   sum;
  logic [SW-1:0] cand;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    sum      = '0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_i} + (SW+1)'(k);
      if (sum >= (SW+1)'(NREQ)) sum = sum - (SW+1)'(NREQ);
      cand = sum[SW-1:0];
      if (!any_o && req_i[cand]) begin
        any_o          = 1'b1;
        idx_o          = cand;
        onehot_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter with a skid register in front of the fifo write port
// A new word is accepted whenever the output register is empty or drains this cycle.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int DSIZE = DSIZE_DEF,
  parameter  int NREQ  = NREQ_DEF,
  localparam int SW    = clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic [DSIZE-1:0]      wdata,
  output logic                  winc,
  input  logic                  wfull,
  output logic [SW-1:0]         out_src,
  output logic                  busy
);

  logic             out_valid_q, out_valid_d;
  logic [DSIZE-1:0] wdata_q, wdata_d;
  logic [SW-1:0]    out_src_q, out_src_d;
  logic [SW-1:0]    ptr_q, ptr_d;

  logic [NREQ-1:0]  pick_onehot;
  logic [SW-1:0]    pick_idx;
  logic             pick_any;
  logic             space;
  logic             accept;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign winc   = out_valid_q & ~wfull & ~rst;
  assign space  = ~out_valid_q | winc;
  assign accept = space & pick_any & ~rst;
  assign gnt    = accept ? pick_onehot : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    wdata_d     = wdata_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      wdata_d     = req_data[int'(pick_idx)*DSIZE +: DSIZE];
      out_src_d   = pick_idx;
      ptr_d       = SW'(next_idx(int'(pick_idx), NREQ));
    end else if (winc) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      wdata_q     <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      wdata_q     <= wdata_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign wdata   = wdata_q;
  assign out_src = out_src_q;
  assign busy    = out_valid_q;

endmodule
